exec_sequencer: RTL and testbench

Run-control and program-counter sequencer for the 8-bit microprocessor core. It owns the PC, chooses the next program-memory address from the decoder's jump outputs and the ALU zero flag, and provides boot-hold, run, halt, single-step and breakpoint control. Its hold output gates the IR load and every datapath register enable, so the core freezes cleanly without the decoder changing.

---
 rtl/exec_sequencer.sv | 119 +++++++++++
 tb/tb_exec_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - run-control FSM and program counter for the 8-bit core
`timescale 1ns/1ps
module exec_sequencer #(
    parameter int          BOOT_CYCLES = 4,
    parameter bit          AUTO_RUN    = 1'b1,
    parameter logic [7:0]  RESET_PC    = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        jmp,
    input  logic        jmp_nz,
    input  logic [3:0]  ir_nibble,
    input  logic        dont_jmp,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd,
    output logic        cmd_ready,
    input  logic        bp_en,
    input  logic [7:0]  bp_addr,
    output logic [7:0]  pc,
    output logic        hold,
    output logic        halted,
    output logic        step_done,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT, S_STEP} state_t;

    localparam int            BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_HALT = 2'b10;
    localparam logic [1:0] CMD_STEP = 2'b11;

    state_t        state, state_nxt;
    logic [BW-1:0] boot_cnt;
    logic          bp_armed;
    logic          bp_hit;
    logic          cmd_acc;
    logic          advance;
    logic          take_jump;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT: begin
                if (boot_cnt == BOOT_LAST) begin
                    state_nxt = AUTO_RUN ? S_RUN : S_HALT;
                end
            end
            S_RUN: begin
                // A breakpoint halts before the instruction at bp_addr executes.
                if (bp_hit || (cmd_acc && cmd == CMD_HALT)) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (cmd_acc && cmd == CMD_RUN) begin
                    state_nxt = S_RUN;
                end else if (cmd_acc && cmd == CMD_STEP) begin
                    state_nxt = S_STEP;
                end
            end
            default: state_nxt = S_HALT;
        endcase
    end

    always_comb begin
        bp_hit    = (state == S_RUN) && bp_en && bp_armed && (pc == bp_addr);
        cmd_ready = (state == S_RUN) || (state == S_HALT);
        halted    = (state == S_HALT);
        hold      = 1'b1;
        case (state)
            S_RUN:   hold = bp_hit;
            S_STEP:  hold = 1'b0;
            default: hold = 1'b1;
        endcase
    end

    assign cmd_acc   = cmd_valid && cmd_ready;
    assign advance   = !hold;
    assign take_jump = jmp || (jmp_nz && !dont_jmp);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            boot_cnt    <= '0;
            instr_count <= 16'h0000;
            bp_armed    <= 1'b0;
            step_done   <= 1'b0;
        end else begin
            step_done <= (state == S_STEP);
            if (state == S_BOOT && boot_cnt != BOOT_LAST) begin
                boot_cnt <= boot_cnt + 1'b1;
            end
            if (advance) begin
                pc <= take_jump ? {pc[7:4], ir_nibble} : pc + 8'd1;
                if (instr_count != 16'hFFFF) begin
                    instr_count <= instr_count + 16'd1;
                end
            end
            // Disarming on resume lets the core step past the breakpoint it stopped on.
            if (state == S_HALT && (state_nxt == S_RUN || state_nxt == S_STEP)) begin
                bp_armed <= 1'b0;
            end else if (advance) begin
                bp_armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed self-checking bench for exec_sequencer
`timescale 1ns/1ps
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        jmp;
    logic        jmp_nz;
    logic [3:0]  ir_nibble;
    logic        dont_jmp;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        cmd_ready;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  pc;
    logic        hold;
    logic        halted;
    logic        step_done;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    exec_sequencer #(
        .BOOT_CYCLES (4),
        .AUTO_RUN    (1'b1),
        .RESET_PC    (8'h00)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .ir_nibble   (ir_nibble),
        .dont_jmp    (dont_jmp),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_ready   (cmd_ready),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc          (pc),
        .hold        (hold),
        .halted      (halted),
        .step_done   (step_done),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cmd(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        cmd_valid = 1'b0;
        cmd       = 2'b00;
    endtask

    task automatic reset_and_boot();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        ticks(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; jmp = 1'b0; jmp_nz = 1'b0; ir_nibble = 4'h0; dont_jmp = 1'b0;
        cmd_valid = 1'b0; cmd = 2'b00; bp_en = 1'b0; bp_addr = 8'h00;
        ticks(2);
        check("rst_pc", pc, 8'h00);
        check("rst_hold", hold, 1);
        check("rst_halted", halted, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_step_done", step_done, 0);
        check("rst_count", instr_count, 0);

        // boot hold lasts exactly four cycles
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("boot_hold", hold, 1);
            check("boot_pc", pc, 8'h00);
            check("boot_ready", cmd_ready, 0);
            tick();
        end
        check("run_hold", hold, 0);
        check("run_ready", cmd_ready, 1);
        check("run_pc0", pc, 8'h00);
        tick();
        check("run_pc1", pc, 8'h01);
        check("run_cnt1", instr_count, 1);
        tick();
        check("run_pc2", pc, 8'h02);
        check("run_cnt2", instr_count, 2);

        // jumps
        ticks(53);
        check("pc_37", pc, 8'h37);
        jmp = 1'b1; ir_nibble = 4'hA; tick(); jmp = 1'b0;
        check("jmp_3a", pc, 8'h3A);
        jmp_nz = 1'b1; dont_jmp = 1'b1; tick();
        check("jnz_suppressed", pc, 8'h3B);
        dont_jmp = 1'b0; ir_nibble = 4'h2; tick(); jmp_nz = 1'b0;
        check("jnz_taken", pc, 8'h32);
        ticks(205);
        check("pc_ff", pc, 8'hFF);
        tick();
        check("pc_wrap", pc, 8'h00);
        check("cnt_264", instr_count, 264);

        // breakpoint at 05 from a fresh boot
        reset_and_boot();
        check("bp_start_pc", pc, 8'h00);
        bp_en = 1'b1; bp_addr = 8'h05;
        ticks(5);
        check("bp_pc", pc, 8'h05);
        check("bp_hold", hold, 1);
        check("bp_not_halted_yet", halted, 0);
        tick();
        check("bp_halted", halted, 1);
        check("bp_pc_kept", pc, 8'h05);
        check("bp_cnt", instr_count, 5);
        send_cmd(2'b01);
        check("resume_halted", halted, 0);
        check("resume_hold", hold, 0);
        tick();
        check("resume_pc", pc, 8'h06);
        check("resume_cnt", instr_count, 6);

        // break at 10, then single steps
        bp_addr = 8'h10;
        ticks(10);
        check("bp10_hold", hold, 1);
        tick();
        check("bp10_halted", halted, 1);
        check("bp10_pc", pc, 8'h10);
        bp_en = 1'b0;
        cmd_valid = 1'b1; cmd = 2'b11;
        #1;
        check("step_ready_halt", cmd_ready, 1);
        tick();
        check("step_hold", hold, 0);
        check("step_ready", cmd_ready, 0);
        check("step_pc_before", pc, 8'h10);
        tick();
        check("step1_pc", pc, 8'h11);
        check("step1_done", step_done, 1);
        check("step1_halted", halted, 1);
        check("step1_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0; cmd = 2'b00;
        check("step2_done_low", step_done, 0);
        check("step2_in_step", hold, 0);
        check("step2_pc_before", pc, 8'h11);
        tick();
        check("step2_pc", pc, 8'h12);
        check("step2_done", step_done, 1);
        tick();
        check("step2_done_once", step_done, 0);
        check("step2_halted", halted, 1);
        check("step2_cnt", instr_count, 18);

        // breakpoint wins over a simultaneous halt command
        bp_en = 1'b1; bp_addr = 8'h14;
        send_cmd(2'b01);
        ticks(2);
        check("bph_pc", pc, 8'h14);
        cmd_valid = 1'b1; cmd = 2'b10;
        #1;
        check("bph_hold", hold, 1);
        check("bph_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0; cmd = 2'b00;
        check("bph_halted", halted, 1);
        check("bph_pc_kept", pc, 8'h14);
        check("bph_cnt", instr_count, 20);

        // halt command in RUN still advances on the accepting cycle
        bp_en = 1'b0;
        send_cmd(2'b01);
        send_cmd(2'b10);
        check("halt_cmd_halted", halted, 1);
        check("halt_cmd_pc", pc, 8'h15);
        check("halt_cmd_cnt", instr_count, 21);

        // asynchronous reset in the middle of a step
        send_cmd(2'b11);
        check("mid_step_hold", hold, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_pc", pc, 8'h00);
        check("async_hold", hold, 1);
        check("async_halted", halted, 0);
        check("async_ready", cmd_ready, 0);
        check("async_step_done", step_done, 0);
        check("async_cnt", instr_count, 0);
        tick();
        reset_n = 1'b1;
        ticks(4);

        // instruction counter saturation
        ticks(65534);
        check("sat_fffe", instr_count, 16'hFFFE);
        tick();
        check("sat_ffff", instr_count, 16'hFFFF);
        ticks(2);
        check("sat_hold", instr_count, 16'hFFFF);
        check("sat_pc", pc, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
